// File: rtl/rpn_uart_pkg.sv
// Shared types, message constants and ASCII helpers for the RPN result UART reporter.
package rpn_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int MSG_LEN = 9;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

endpackage

// File: rtl/rpn_result_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles.
// ready is high in the cycle where a new byte can be taken; when a byte is
// taken at the end of a stop bit the next start bit follows with no gap.
module uart_tx_byte
    import rpn_uart_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    tx_state_t     state_r;
    logic [CW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          bit_end_s;

    assign bit_end_s = (baud_cnt_r == CNT_LAST);
    assign ready     = (state_r == IDLE) || ((state_r == STOP) && bit_end_s);
    assign tx        = tx_r;

    // Framing FSM with baud counter, bit index and registered line output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    if (valid) begin
                        shift_r <= data;
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                        shift_r    <= {1'b0, shift_r[7:1]};
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        bit_idx_r  <= 3'd0;
                        if (valid) begin
                            shift_r <= data;
                            tx_r    <= 1'b0;
                            state_r <= START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rpn_result_uart_tx.sv
// Reports each ALU result/flags pair as "RRRR FF\r\n" over a UART line.
module rpn_result_uart_tx
    import rpn_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] result,
    input  logic [4:0]  flags,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        dropped
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    logic        busy_r;
    logic        done_r;
    logic        dropped_r;
    logic [3:0]  char_idx_r;
    logic [15:0] res_snap_r;
    logic [4:0]  flg_snap_r;
    logic        byte_valid_s;
    logic [7:0]  byte_data_s;
    logic        byte_ready_s;

    // Character idx of the message for the given values.
    function automatic logic [7:0] msg_char(input logic [3:0] idx,
                                            input logic [15:0] res,
                                            input logic [4:0] flg);
        logic [7:0] c;
        case (idx)
            4'd0:    c = hex_to_ascii(res[15:12]);
            4'd1:    c = hex_to_ascii(res[11:8]);
            4'd2:    c = hex_to_ascii(res[7:4]);
            4'd3:    c = hex_to_ascii(res[3:0]);
            4'd4:    c = SPACE;
            4'd5:    c = hex_to_ascii({3'b000, flg[4]});
            4'd6:    c = hex_to_ascii(flg[3:0]);
            4'd7:    c = CR;
            4'd8:    c = LF;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Next byte offered to the serializer: the first character straight from
    // the inputs on an accepted send, later characters from the snapshot.
    always_comb begin
        byte_valid_s = 1'b0;
        byte_data_s  = 8'h00;
        if (!busy_r) begin
            byte_valid_s = send;
            byte_data_s  = msg_char(4'd0, result, flags);
        end else begin
            byte_valid_s = (char_idx_r < LAST_IDX);
            byte_data_s  = msg_char(char_idx_r + 4'd1, res_snap_r, flg_snap_r);
        end
    end

    // Message sequencing: snapshot capture, character index, status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dropped_r  <= 1'b0;
            char_idx_r <= 4'd0;
            res_snap_r <= 16'h0000;
            flg_snap_r <= 5'b00000;
        end else begin
            done_r    <= 1'b0;
            dropped_r <= 1'b0;
            if (!busy_r) begin
                if (send) begin
                    busy_r     <= 1'b1;
                    char_idx_r <= 4'd0;
                    res_snap_r <= result;
                    flg_snap_r <= flags;
                end else begin
                    char_idx_r <= 4'd0;
                end
            end else begin
                if (send) begin
                    dropped_r <= 1'b1;
                end else begin
                    dropped_r <= 1'b0;
                end
                if (byte_ready_s) begin
                    if (char_idx_r < LAST_IDX) begin
                        char_idx_r <= char_idx_r + 4'd1;
                    end else begin
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        char_idx_r <= 4'd0;
                    end
                end else begin
                    char_idx_r <= char_idx_r;
                end
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk   (clk),
        .reset (reset),
        .valid (byte_valid_s),
        .data  (byte_data_s),
        .ready (byte_ready_s),
        .tx    (tx)
    );

    assign busy    = busy_r;
    assign done    = done_r;
    assign dropped = dropped_r;

endmodule

// File: tb/tb_rpn_result_uart_tx.sv
// Scoreboard bench for rpn_result_uart_tx with BAUD_DIV = 10.
module tb_rpn_result_uart_tx;

    localparam int DIV = 10;

    logic        clk;
    logic        reset;
    logic        send;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        tx;
    logic        busy;
    logic        done;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    byte unsigned exp_q[$];

    int busy_cnt    = 0;
    int done_cnt    = 0;
    int dropped_cnt = 0;
    int rx_bytes    = 0;
    bit rx_active   = 0;

    rpn_result_uart_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .result  (result),
        .flags   (flags),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .dropped (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Status pulse counters, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (dropped === 1'b1) dropped_cnt++;
        end
    end

    // UART receiver: checks bit stability over each 10-cycle window,
    // the stop bit, and compares every byte against the scoreboard.
    initial begin
        int off;
        logic level;
        bit unstable;
        logic [7:0] rx_byte;
        byte unsigned exp_b;
        off = 0; level = 1'b1; unstable = 0; rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rx_active = 0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    off = 0;
                    level = 1'b0;
                    unstable = 0;
                end
            end else begin
                off++;
                if (off % DIV == 0) begin
                    level = tx;
                end else if (tx !== level) begin
                    unstable = 1;
                end
                if ((off % DIV == 5) && (off / DIV >= 1) && (off / DIV <= 8)) begin
                    rx_byte[off / DIV - 1] = tx;
                end
                if (off == 10 * DIV - 1) begin
                    rx_active = 0;
                    rx_bytes++;
                    checks++;
                    if (unstable || level !== 1'b1) begin
                        errors++;
                        $display("FAIL bit_timing: byte %0d unstable=%0d stop=%b, required stable 10-cycle bits and stop=1",
                                 rx_bytes, unstable, level);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_byte: got unexpected byte 0x%02h, required none", rx_byte);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (rx_byte !== exp_b) begin
                            errors++;
                            $display("FAIL rx_byte: got 0x%02h, required 0x%02h", rx_byte, exp_b);
                        end
                    end
                end
            end
        end
    end

    function automatic byte unsigned hexc(input logic [3:0] n);
        byte unsigned c;
        if (n < 4'd10) c = 8'h30 + n;
        else c = 8'h41 + (n - 4'd10);
        return c;
    endfunction

    task automatic push_msg(input logic [15:0] r, input logic [4:0] f);
        exp_q.push_back(hexc(r[15:12]));
        exp_q.push_back(hexc(r[11:8]));
        exp_q.push_back(hexc(r[7:4]));
        exp_q.push_back(hexc(r[3:0]));
        exp_q.push_back(8'h20);
        exp_q.push_back(hexc({3'b000, f[4]}));
        exp_q.push_back(hexc(f[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; dropped_cnt = 0; rx_bytes = 0;
    endtask

    // Drives one send pulse at a negedge and queues the expected line.
    task automatic send_msg(input logic [15:0] r, input logic [4:0] f);
        send = 1'b1; result = r; flags = f;
        push_msg(r, f);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && !rx_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 1'b0; result = 16'h0000; flags = 5'b00000;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, done, dropped} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state: tx,busy,done,dropped=%b, required 1000", {tx, busy, done, dropped});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_counts();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle_tx: got %b, required 1", tx);
        end
        send_msg(16'h1A2F, 5'b10011);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: tx=%b busy=%b one cycle after send, required tx=0 busy=1", tx, busy);
        end
        wait_idle("basic");
        check_int("basic_busy_cycles", busy_cnt, 900);
        check_int("basic_done_pulses", done_cnt, 1);
        check_int("basic_bytes", rx_bytes, 9);
        check_int("basic_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_snapshot();
        clear_counts();
        send_msg(16'h0000, 5'b00000);
        result = 16'hFFFF; flags = 5'b11111;
        wait_idle("snapshot");
        check_int("snapshot_bytes", rx_bytes, 9);
        check_int("snapshot_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_dropped();
        bit line_low;
        clear_counts();
        send_msg(16'h7C05, 5'b01010);
        repeat (49) @(negedge clk);
        send = 1'b1; result = 16'h9999; flags = 5'b11111;
        @(negedge clk);
        send = 1'b0;
        wait_idle("dropped");
        line_low = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) line_low = 1;
        end
        checks++;
        if (line_low) begin
            errors++;
            $display("FAIL idle_line: tx/busy active after message, required tx=1 busy=0");
        end
        check_int("dropped_pulses", dropped_cnt, 1);
        check_int("dropped_done_pulses", done_cnt, 1);
        check_int("dropped_bytes", rx_bytes, 9);
        check_int("dropped_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_back_to_back();
        int n;
        clear_counts();
        send_msg(16'h0123, 5'b00100);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL b2b_done_timeout: done=%b, required 1", done);
        end
        send_msg(16'hBEEF, 5'b00001);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
        end
        wait_idle("b2b");
        check_int("b2b_busy_cycles", busy_cnt, 1800);
        check_int("b2b_done_pulses", done_cnt, 2);
        check_int("b2b_bytes", rx_bytes, 18);
        check_int("b2b_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_msg(16'h4D6E, 5'b11100);
        repeat (429) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check_int("midreset_no_done", done_cnt, 0);
        check_int("midreset_partial_bytes", rx_bytes, 4);
        clear_counts();
        send_msg(16'hC0DE, 5'b00110);
        wait_idle("midreset_resend");
        check_int("midreset_resend_bytes", rx_bytes, 9);
        check_int("midreset_resend_done", done_cnt, 1);
        check_int("midreset_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_dropped();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
